// File: rtl/pwm_shadow_sched.sv
// Shadow-register update scheduler for the PWM carrier bank. Commits are held
// pending per channel and moved into the active period/compare registers on a
// qualifying, decimated carrier min/max event, on force, or when the carrier stops.
module pwm_shadow_sched #(
  parameter int NCH = 8,
  parameter int CW  = 16,
  parameter int EW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    commit_i,
  input  logic [NCH-1:0]    force_i,
  input  logic [NCH-1:0]    ch_on_i,
  input  logic [2*NCH-1:0]  mask_mode_i,
  input  logic [EW*NCH-1:0] evt_div_i,
  input  logic [NCH-1:0]    int_en_i,
  input  logic [NCH-1:0]    int_clr_i,
  input  logic [NCH-1:0]    evt_min_i,
  input  logic [NCH-1:0]    evt_max_i,
  input  logic [CW*NCH-1:0] shd_period_i,
  input  logic [CW*NCH-1:0] shd_cmp_i,
  output logic [CW*NCH-1:0] act_period_o,
  output logic [CW*NCH-1:0] act_cmp_o,
  output logic [NCH-1:0]    load_stb_o,
  output logic [NCH-1:0]    pending_o,
  output logic [NCH-1:0]    int_flag_o,
  output logic              irq_o
);

  typedef enum logic {IDLE, ARMED} state_e;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e        state_q, state_d;
    logic [EW-1:0] evt_cnt_q, evt_cnt_d;
    logic [CW-1:0] stg_period_q, stg_period_d, stg_cmp_q, stg_cmp_d;
    logic [CW-1:0] act_period_q, act_period_d, act_cmp_q, act_cmp_d;
    logic [CW-1:0] ld_period, ld_cmp;
    logic          load_stb_q, load_stb_d, int_flag_q, int_flag_d;
    logic          qual, do_load;

    // A min and a max in the same cycle collapse into a single qualifying event.
    assign qual = (evt_min_i[i] & ~mask_mode_i[2*i]) | (evt_max_i[i] & ~mask_mode_i[2*i+1]);

    always_comb begin
      // NOTE: every signal written here gets a default first so no path infers a latch.
      state_d      = state_q;
      evt_cnt_d    = evt_cnt_q;
      stg_period_d = stg_period_q;
      stg_cmp_d    = stg_cmp_q;
      act_period_d = act_period_q;
      act_cmp_d    = act_cmp_q;
      ld_period    = stg_period_q;
      ld_cmp       = stg_cmp_q;
      load_stb_d   = 1'b0;
      do_load      = 1'b0;

      if (commit_i[i]) begin
        evt_cnt_d = '0;
        if (ch_on_i[i]) begin
          stg_period_d = shd_period_i[i*CW +: CW];
          stg_cmp_d    = shd_cmp_i[i*CW +: CW];
          state_d      = ARMED;
        end else begin
          do_load   = 1'b1;
          ld_period = shd_period_i[i*CW +: CW];
          ld_cmp    = shd_cmp_i[i*CW +: CW];
        end
      end else if (state_q == ARMED) begin
        // The >= compare keeps a shrunk live divider from letting the counter wrap.
        if (force_i[i] || !ch_on_i[i] || (qual && (evt_cnt_q >= evt_div_i[i*EW +: EW])))
          do_load = 1'b1;
        else if (qual)
          evt_cnt_d = evt_cnt_q + EW'(1'b1);
      end

      if (do_load) begin
        act_period_d = ld_period;
        act_cmp_d    = ld_cmp;
        load_stb_d   = 1'b1;
        evt_cnt_d    = '0;
        state_d      = IDLE;
      end

      int_flag_d = int_flag_q;
      if (do_load && int_en_i[i]) int_flag_d = 1'b1;
      else if (int_clr_i[i])      int_flag_d = 1'b0;
    end

    // NOTE: staging registers are reset too, so a stale snapshot can never resurface.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q      <= IDLE;
        evt_cnt_q    <= '0;
        stg_period_q <= '0;
        stg_cmp_q    <= '0;
        act_period_q <= '1;
        act_cmp_q    <= '0;
        load_stb_q   <= 1'b0;
        int_flag_q   <= 1'b0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments only.
        state_q      <= state_d;
        evt_cnt_q    <= evt_cnt_d;
        stg_period_q <= stg_period_d;
        stg_cmp_q    <= stg_cmp_d;
        act_period_q <= act_period_d;
        act_cmp_q    <= act_cmp_d;
        load_stb_q   <= load_stb_d;
        int_flag_q   <= int_flag_d;
      end
    end

    assign act_period_o[i*CW +: CW] = act_period_q;
    assign act_cmp_o[i*CW +: CW]    = act_cmp_q;
    assign load_stb_o[i]            = load_stb_q;
    assign pending_o[i]             = (state_q == ARMED);
    assign int_flag_o[i]            = int_flag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_o <= 1'b0;
    else        irq_o <= |int_flag_o;
  end

endmodule

// File: tb/tb_pwm_shadow_sched.sv
// Self-checking bench for pwm_shadow_sched: directed scenarios followed by random
// traffic, all compared each cycle against a per-channel behavioural model.
module tb_pwm_shadow_sched;
  localparam int NCH = 8, CW = 16, EW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    commit, frc, ch_on, int_en, int_clr, evt_min, evt_max;
  logic [2*NCH-1:0]  mask_mode;
  logic [EW*NCH-1:0] evt_div;
  logic [CW*NCH-1:0] shd_period, shd_cmp, act_period, act_cmp;
  logic [NCH-1:0]    load_stb, pending, int_flag;
  logic              irq;

  int total = 0;
  int bad   = 0;

  // Behavioural model: what each channel holds, kept as plain integers.
  int m_pend[NCH], m_cnt[NCH], m_stg_p[NCH], m_stg_c[NCH];
  int m_act_p[NCH], m_act_c[NCH], m_flag[NCH], m_stb[NCH];
  int m_irq;

  pwm_shadow_sched #(.NCH(NCH), .CW(CW), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .commit_i(commit), .force_i(frc), .ch_on_i(ch_on),
    .mask_mode_i(mask_mode), .evt_div_i(evt_div), .int_en_i(int_en), .int_clr_i(int_clr),
    .evt_min_i(evt_min), .evt_max_i(evt_max), .shd_period_i(shd_period), .shd_cmp_i(shd_cmp),
    .act_period_o(act_period), .act_cmp_o(act_cmp), .load_stb_o(load_stb),
    .pending_o(pending), .int_flag_o(int_flag), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = 0; m_cnt[i] = 0; m_stg_p[i] = 0; m_stg_c[i] = 0;
      m_act_p[i] = 16'hFFFF; m_act_c[i] = 0; m_flag[i] = 0; m_stb[i] = 0;
    end
    m_irq = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int any_flag = 0;
    for (int i = 0; i < NCH; i++) if (m_flag[i] != 0) any_flag = 1;
    for (int i = 0; i < NCH; i++) begin
      int  div = int'(evt_div[i*EW +: EW]);
      bit  q   = (evt_min[i] && !mask_mode[2*i]) || (evt_max[i] && !mask_mode[2*i+1]);
      bit  ld  = 0;
      int  np  = m_stg_p[i], nc = m_stg_c[i];
      m_stb[i] = 0;
      if (commit[i]) begin
        m_cnt[i] = 0;
        if (ch_on[i]) begin
          m_stg_p[i] = int'(shd_period[i*CW +: CW]);
          m_stg_c[i] = int'(shd_cmp[i*CW +: CW]);
          m_pend[i]  = 1;
        end else begin
          ld = 1; np = int'(shd_period[i*CW +: CW]); nc = int'(shd_cmp[i*CW +: CW]);
        end
      end else if (m_pend[i] != 0) begin
        if (frc[i] || !ch_on[i] || (q && m_cnt[i] >= div)) ld = 1;
        else if (q) m_cnt[i]++;
      end
      if (ld) begin
        m_act_p[i] = np; m_act_c[i] = nc; m_stb[i] = 1; m_pend[i] = 0; m_cnt[i] = 0;
      end
      if (ld && int_en[i]) m_flag[i] = 1;
      else if (int_clr[i]) m_flag[i] = 0;
    end
    m_irq = any_flag;
  endtask

  task automatic compare_all();
    logic [127:0] ep, ec;
    logic [7:0]   es, epd, ef;
    ep = '0; ec = '0; es = '0; epd = '0; ef = '0;
    for (int i = 0; i < NCH; i++) begin
      ep[i*CW +: CW] = CW'(m_act_p[i]);
      ec[i*CW +: CW] = CW'(m_act_c[i]);
      es[i] = m_stb[i][0]; epd[i] = m_pend[i][0]; ef[i] = m_flag[i][0];
    end
    check("act_period", act_period, ep);
    check("act_cmp", act_cmp, ec);
    check("load_stb", 128'(load_stb), 128'(es));
    check("pending", 128'(pending), 128'(epd));
    check("int_flag", 128'(int_flag), 128'(ef));
    check("irq", 128'(irq), 128'(m_irq[0]));
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge with pulses cleared.
  task automatic tick();
    model_step();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    commit = '0; frc = '0; int_clr = '0; evt_min = '0; evt_max = '0;
  endtask

  task automatic set_shd(input int ch, input int p, input int c);
    shd_period[ch*CW +: CW] = CW'(p);
    shd_cmp[ch*CW +: CW]    = CW'(c);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; commit = '0; frc = '0; ch_on = '1; int_en = '0; int_clr = '0;
    evt_min = '0; evt_max = '0; mask_mode = '0; evt_div = '0;
    shd_period = '0; shd_cmp = '0;
    #3;
    apply_reset();

    // ch0: NO_MASK, div 0, single max event loads one cycle later.
    set_shd(0, 1000, 250); commit[0] = 1'b1; tick();
    evt_max[0] = 1'b1; tick();
    check("ch0_period", 128'(act_period[15:0]), 128'(16'd1000));
    check("ch0_cmp", 128'(act_cmp[15:0]), 128'(16'd250));
    tick();

    // ch3: MAX_MASK (max masked), div 2: only the 3rd min event loads.
    mask_mode[7:6] = 2'b10; evt_div[3*EW +: EW] = 3'd2;
    set_shd(3, 4321, 99); commit[3] = 1'b1; tick();
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) evt_max[3] = 1'b1; else evt_min[3] = 1'b1;
      tick();
    end
    check("ch3_period", 128'(act_period[3*CW +: CW]), 128'(16'd4321));
    tick();

    // ch1: armed with one event counted, recommit alongside a qualifying event.
    evt_div[1*EW +: EW] = 3'd1;
    set_shd(1, 111, 11); commit[1] = 1'b1; tick();
    evt_min[1] = 1'b1; tick();
    set_shd(1, 222, 22); commit[1] = 1'b1; evt_min[1] = 1'b1; tick();
    evt_min[1] = 1'b1; tick();
    check("ch1_not_yet", 128'(pending[1]), 128'(1'b1));
    evt_max[1] = 1'b1; tick();
    check("ch1_period", 128'(act_period[1*CW +: CW]), 128'(16'd222));

    // ch5: carrier stopped, commit loads directly.
    ch_on[5] = 1'b0; set_shd(5, 500, 50); commit[5] = 1'b1; tick();
    check("ch5_period", 128'(act_period[5*CW +: CW]), 128'(16'd500));
    ch_on[5] = 1'b1; tick();

    // ch2: MINMAX_MASK ignores every event until force.
    mask_mode[5:4] = 2'b11; set_shd(2, 777, 7); commit[2] = 1'b1; tick();
    for (int k = 0; k < 10; k++) begin
      evt_min[2] = k[0]; evt_max[2] = ~k[0]; tick();
    end
    frc[2] = 1'b1; tick();
    check("ch2_period", 128'(act_period[2*CW +: CW]), 128'(16'd777));

    // ch7: set of int_flag wins over a simultaneous clear; irq follows a cycle later.
    int_en[7] = 1'b1; set_shd(7, 900, 300); commit[7] = 1'b1; tick();
    evt_min[7] = 1'b1; int_clr[7] = 1'b1; tick();
    check("ch7_flag_kept", 128'(int_flag[7]), 128'(1'b1));
    tick();
    check("ch7_irq", 128'(irq), 128'(1'b1));
    int_clr[7] = 1'b1; tick();
    tick();
    check("ch7_irq_clr", 128'(irq), 128'(1'b0));

    // Random traffic with live changes to masks, dividers and enables.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) mask_mode = 16'($urandom);
      if ($urandom_range(0, 15) == 0) evt_div   = 24'($urandom);
      if ($urandom_range(0, 7) == 0)  int_en    = 8'($urandom);
      for (int i = 0; i < NCH; i++) begin
        ch_on[i]   = ($urandom_range(0, 9) != 0);
        commit[i]  = ($urandom_range(0, 19) == 0);
        frc[i]     = ($urandom_range(0, 39) == 0);
        int_clr[i] = ($urandom_range(0, 9) == 0);
        evt_min[i] = ($urandom_range(0, 3) == 0);
        evt_max[i] = ($urandom_range(0, 3) == 0);
      end
      shd_period = {$urandom, $urandom, $urandom, $urandom};
      shd_cmp    = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (n == 1500) apply_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
